evaluate_pv_multi: RTL and testbench

Multi-slot successor to the single-entry PV evaluator. Per search ply it holds NUM_SLOTS reference moves: slot 0 is the principal-variation move, slots 1..NUM_SLOTS-1 are killer/hint moves. On each new board it compares the incoming UCI move against every valid slot at the current ply and reports a match flag plus the winning slot index. It has its own latency sequencer. It sits beside the other evaluator leaves, and its outputs feed move-ordering score accumulation.

---
 rtl/evaluate_pv_pkg.sv | 22 ++
 rtl/pv_latency_seq.sv | 76 +++++++
 rtl/evaluate_pv_multi.sv | 127 ++++++++++++
 tb/tb_evaluate_pv_multi.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/evaluate_pv_pkg.sv
// rtl/evaluate_pv_pkg.sv - shared control-word layout and sequencer states for the PV evaluator
package evaluate_pv_pkg;

  localparam int WRITE_BIT     = 31;
  localparam int CLEAR_ALL_BIT = 30;

  // Control-word fields pack upward from bit 0: move, ply, entry_valid, slot.
  function automatic int ply_lsb(input int uci_width);
    return uci_width;
  endfunction

  function automatic int entry_valid_bit(input int uci_width, input int depth_log2);
    return uci_width + depth_log2;
  endfunction

  function automatic int slot_lsb(input int uci_width, input int depth_log2);
    return uci_width + depth_log2 + 1;
  endfunction

  typedef enum logic [1:0] {IDLE, WAIT, DONE} seq_state_e;

endpackage

// File: rtl/pv_latency_seq.sv
// rtl/pv_latency_seq.sv - edge-triggered latency sequencer producing eval_valid and start/abort/finish strobes
module pv_latency_seq
  import evaluate_pv_pkg::*;
#(
  parameter int LATENCY_COUNT = 2
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic board_valid_i,
  input  logic clear_eval_i,
  output logic start_o,
  output logic abort_o,
  output logic finish_o,
  output logic eval_valid_o
);

  localparam int CNT_W = $clog2(LATENCY_COUNT);

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bv_q, ce_q;
  logic             bv_rise, ce_rise;

  assign bv_rise      = board_valid_i & ~bv_q;
  assign ce_rise      = clear_eval_i & ~ce_q;
  assign eval_valid_o = (state_q == DONE);

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bv_q    <= 1'b0;
      ce_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bv_q    <= board_valid_i;
      ce_q    <= clear_eval_i;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    start_o  = 1'b0;
    abort_o  = 1'b0;
    finish_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (bv_rise) begin
          start_o = 1'b1;
          state_d = WAIT;
          cnt_d   = CNT_W'(LATENCY_COUNT - 1);
        end
      end
      WAIT: begin
        if (ce_rise) begin
          abort_o = 1'b1;
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        if (ce_rise) begin
          finish_o = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: rtl/evaluate_pv_multi.sv
// rtl/evaluate_pv_multi.sv - per-ply multi-slot PV/killer move table with compare and priority encode
module evaluate_pv_multi
  import evaluate_pv_pkg::*;
#(
  parameter int UCI_WIDTH      = 16,
  parameter int MAX_DEPTH_LOG2 = 5,
  parameter int SLOT_LOG2      = 1,
  parameter int LATENCY_COUNT  = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      board_valid,
  input  logic [UCI_WIDTH-1:0]      uci_in,
  input  logic [MAX_DEPTH_LOG2-1:0] pv_ply,
  input  logic                      clear_eval,
  input  logic [31:0]               pv_ctrl_in,
  output logic                      eval_pv_flag,
  output logic [SLOT_LOG2-1:0]      eval_match_slot,
  output logic                      eval_valid
);

  localparam int NUM_SLOTS = 2 ** SLOT_LOG2;
  localparam int IDX_W     = MAX_DEPTH_LOG2 + SLOT_LOG2;
  localparam int ENTRIES   = 2 ** IDX_W;
  localparam int PLY_LSB   = ply_lsb(UCI_WIDTH);
  localparam int EV_BIT    = entry_valid_bit(UCI_WIDTH, MAX_DEPTH_LOG2);
  localparam int SLOT_LSB  = slot_lsb(UCI_WIDTH, MAX_DEPTH_LOG2);

  if ((UCI_WIDTH + MAX_DEPTH_LOG2 + 1 + SLOT_LOG2 > 30) || (LATENCY_COUNT < 2)) begin : g_cfg_check
    $error("evaluate_pv_multi: control word fields overlap or LATENCY_COUNT < 2");
  end

  logic                      wr_en, clr_all, wr_ev;
  logic [UCI_WIDTH-1:0]      wr_move;
  logic [IDX_W-1:0]          wr_idx;
  logic                      ctrl_unused;

  assign wr_en       = pv_ctrl_in[WRITE_BIT];
  assign clr_all     = pv_ctrl_in[CLEAR_ALL_BIT];
  assign wr_move     = pv_ctrl_in[UCI_WIDTH-1:0];
  assign wr_ev       = pv_ctrl_in[EV_BIT];
  assign wr_idx      = {pv_ctrl_in[PLY_LSB +: MAX_DEPTH_LOG2], pv_ctrl_in[SLOT_LSB +: SLOT_LOG2]};
  assign ctrl_unused = ^pv_ctrl_in;

  logic start, abort, finish;

  pv_latency_seq #(.LATENCY_COUNT(LATENCY_COUNT)) u_seq (
    .clk_i        (clk),
    .reset_i      (reset),
    .board_valid_i(board_valid),
    .clear_eval_i (clear_eval),
    .start_o      (start),
    .abort_o      (abort),
    .finish_o     (finish),
    .eval_valid_o (eval_valid)
  );

  logic [UCI_WIDTH-1:0]      move_mem_q [ENTRIES];
  logic [ENTRIES-1:0]        valid_q, valid_d;
  logic [NUM_SLOTS-1:0]      cmp_q, cmp_d, cmp_now;
  logic [MAX_DEPTH_LOG2-1:0] ply_q, ply_d;
  logic                      pend_q, pend_d;
  logic                      flag_q, flag_d;
  logic [SLOT_LOG2-1:0]      slot_q, slot_d, enc_slot;

  always_ff @(posedge clk) begin
    if (wr_en) move_mem_q[wr_idx] <= wr_move;
  end

  // Compared in the capture cycle, so a same-cycle write is not seen.
  always_comb begin
    cmp_now = '0;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      cmp_now[s] = valid_q[{pv_ply, SLOT_LOG2'(s)}] &&
                   (move_mem_q[{pv_ply, SLOT_LOG2'(s)}] == uci_in);
    end
  end

  always_comb begin
    enc_slot = '0;
    for (int s = NUM_SLOTS - 1; s >= 0; s--) begin
      if (cmp_q[s]) enc_slot = SLOT_LOG2'(s);
    end
  end

  always_comb begin
    ply_d  = start ? pv_ply : ply_q;
    cmp_d  = start ? cmp_now : cmp_q;
    pend_d = start;
    flag_d = flag_q;
    slot_d = slot_q;
    if (abort) begin
      flag_d = 1'b0;
      slot_d = '0;
    end else if (pend_q) begin
      flag_d = |cmp_q;
      slot_d = enc_slot;
    end
    valid_d = valid_q;
    if (clr_all) valid_d = '0;
    // Consumed PV move retires; killers persist and an explicit write still wins.
    if (finish && flag_q && (slot_q == '0)) valid_d[{ply_q, SLOT_LOG2'(0)}] = 1'b0;
    if (wr_en) valid_d[wr_idx] = wr_ev;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q <= '0;
      cmp_q   <= '0;
      ply_q   <= '0;
      pend_q  <= 1'b0;
      flag_q  <= 1'b0;
      slot_q  <= '0;
    end else begin
      valid_q <= valid_d;
      cmp_q   <= cmp_d;
      ply_q   <= ply_d;
      pend_q  <= pend_d;
      flag_q  <= flag_d;
      slot_q  <= slot_d;
    end
  end

  assign eval_pv_flag    = flag_q;
  assign eval_match_slot = slot_q;

endmodule

// File: tb/tb_evaluate_pv_multi.sv
// tb/tb_evaluate_pv_multi.sv - directed vector bench for evaluate_pv_multi (default and 4-slot/latency-4 builds)
module tb_evaluate_pv_multi;

  logic        clk;
  logic        reset;
  logic        board_valid;
  logic [15:0] uci_in;
  logic [4:0]  pv_ply;
  logic        clear_eval;
  logic [31:0] pv_ctrl_in;
  logic        flag_a, ev_a, flag_b, ev_b;
  logic [0:0]  slot_a;
  logic [1:0]  slot_b;
  logic        use_b;
  logic        cur_ev, cur_flag;
  logic [1:0]  cur_slot;
  int          n_cmp, n_fail;

  evaluate_pv_multi dut_a (
    .clk(clk), .reset(reset), .board_valid(board_valid), .uci_in(uci_in),
    .pv_ply(pv_ply), .clear_eval(clear_eval), .pv_ctrl_in(pv_ctrl_in),
    .eval_pv_flag(flag_a), .eval_match_slot(slot_a), .eval_valid(ev_a)
  );

  evaluate_pv_multi #(.SLOT_LOG2(2), .LATENCY_COUNT(4)) dut_b (
    .clk(clk), .reset(reset), .board_valid(board_valid), .uci_in(uci_in),
    .pv_ply(pv_ply), .clear_eval(clear_eval), .pv_ctrl_in(pv_ctrl_in),
    .eval_pv_flag(flag_b), .eval_match_slot(slot_b), .eval_valid(ev_b)
  );

  assign cur_ev   = use_b ? ev_b : ev_a;
  assign cur_flag = use_b ? flag_b : flag_a;
  assign cur_slot = use_b ? slot_b : {1'b0, slot_a};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pre_ctrl;
    logic [31:0] cap_ctrl;
    logic [15:0] uci;
    logic [4:0]  ply;
    logic        exp_flag;
    logic [1:0]  exp_slot;
  } vec_t;

  vec_t vecs [15];

  function automatic logic [31:0] mk(input logic [15:0] mv, input logic [4:0] ply,
                                     input logic ev, input logic [1:0] slot, input logic clr);
    logic [31:0] w;
    w        = '0;
    w[31]    = 1'b1;
    w[30]    = clr;
    w[15:0]  = mv;
    w[20:16] = ply;
    w[21]    = ev;
    w[23:22] = slot;
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [31:0] w);
    pv_ctrl_in = w;
    tick();
    pv_ctrl_in = '0;
  endtask

  // The first tick is the edge that samples the rise, so eval_valid is seen after lat+1 ticks.
  task automatic run_lookup(input logic [31:0] cap, input logic [15:0] uci, input logic [4:0] ply,
                            input logic ef, input logic [1:0] es, input int lat, input string nm);
    int n;
    uci_in      = uci;
    pv_ply      = ply;
    board_valid = 1'b1;
    pv_ctrl_in  = cap;
    n = 0;
    do begin
      tick();
      pv_ctrl_in = '0;
      n++;
    end while (!cur_ev && n < lat + 6);
    check({nm, " latency"}, n, lat + 1);
    check({nm, " flag"}, cur_flag, ef);
    check({nm, " slot"}, cur_slot, es);
    board_valid = 1'b0;
    clear_eval  = 1'b1;
    tick();
    check({nm, " valid_drop"}, cur_ev, 1'b0);
    clear_eval = 1'b0;
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int  n;
    logic seen;
    n_cmp = 0; n_fail = 0;
    reset = 1'b0; board_valid = 1'b0; clear_eval = 1'b0;
    uci_in = '0; pv_ply = '0; pv_ctrl_in = '0; use_b = 1'b0;
    repeat (3) tick();
    check("reset eval_valid", ev_a, 1'b0);
    check("reset flag", flag_a, 1'b0);
    check("reset slot", slot_a, 1'b0);
    reset = 1'b1;
    tick();

    wr(mk(16'h1234, 5'd3, 1'b1, 2'd0, 1'b0));
    wr(mk(16'h0AAA, 5'd5, 1'b1, 2'd0, 1'b0));
    wr(mk(16'h0BBB, 5'd5, 1'b1, 2'd1, 1'b0));
    wr(mk(16'h0555, 5'd7, 1'b1, 2'd1, 1'b0));

    vecs[0]  = '{32'h0, 32'h0, 16'h1234, 5'd3, 1'b1, 2'd0};
    vecs[1]  = '{32'h0, 32'h0, 16'h1234, 5'd3, 1'b0, 2'd0};
    vecs[2]  = '{32'h0, 32'h0, 16'h0BBB, 5'd5, 1'b1, 2'd1};
    vecs[3]  = '{32'h0, 32'h0, 16'h0CCC, 5'd5, 1'b0, 2'd0};
    vecs[4]  = '{32'h0, 32'h0, 16'h0555, 5'd7, 1'b1, 2'd1};
    vecs[5]  = '{32'h0, 32'h0, 16'h0555, 5'd7, 1'b1, 2'd1};
    vecs[6]  = '{32'h0, 32'h0, 16'h0AAA, 5'd5, 1'b1, 2'd0};
    vecs[7]  = '{32'h0, 32'h0, 16'h0AAA, 5'd5, 1'b0, 2'd0};
    vecs[8]  = '{32'h0, 32'h0, 16'h0BBB, 5'd5, 1'b1, 2'd1};
    vecs[9]  = '{32'h0, 32'h0, 16'h1234, 5'd4, 1'b0, 2'd0};
    vecs[10] = '{32'h0, mk(16'h0999, 5'd9, 1'b1, 2'd0, 1'b0), 16'h0999, 5'd9, 1'b0, 2'd0};
    vecs[11] = '{32'h0, 32'h0, 16'h0999, 5'd9, 1'b1, 2'd0};
    vecs[12] = '{mk(16'h0777, 5'd2, 1'b1, 2'd1, 1'b1), 32'h0, 16'h0777, 5'd2, 1'b1, 2'd1};
    vecs[13] = '{32'h0, 32'h0, 16'h0BBB, 5'd5, 1'b0, 2'd0};
    vecs[14] = '{32'h0, 32'h0, 16'h0555, 5'd7, 1'b0, 2'd0};

    for (int i = 0; i < 15; i++) begin
      if (vecs[i].pre_ctrl != 32'h0) wr(vecs[i].pre_ctrl);
      run_lookup(vecs[i].cap_ctrl, vecs[i].uci, vecs[i].ply, vecs[i].exp_flag,
                 vecs[i].exp_slot, 2, $sformatf("vec%0d", i));
    end

    // clear_eval during WAIT aborts without retiring the PV entry
    wr(mk(16'h0B0B, 5'd11, 1'b1, 2'd0, 1'b0));
    uci_in = 16'h0B0B; pv_ply = 5'd11; board_valid = 1'b1;
    tick();
    clear_eval = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      tick();
      if (ev_a) seen = 1'b1;
    end
    check("abort eval_valid_seen", seen, 1'b0);
    check("abort flag", flag_a, 1'b0);
    check("abort slot", slot_a, 1'b0);
    board_valid = 1'b0; clear_eval = 1'b0;
    tick();
    run_lookup(32'h0, 16'h0B0B, 5'd11, 1'b1, 2'd0, 2, "abort_retry");

    // reset while in DONE
    uci_in = 16'h0777; pv_ply = 5'd2; board_valid = 1'b1;
    repeat (3) tick();
    check("done eval_valid", ev_a, 1'b1);
    check("done flag", flag_a, 1'b1);
    check("done slot", slot_a, 1'b1);
    reset = 1'b0; board_valid = 1'b0;
    tick();
    check("midreset eval_valid", ev_a, 1'b0);
    check("midreset flag", flag_a, 1'b0);
    check("midreset slot", slot_a, 1'b0);
    reset = 1'b1;
    tick();
    run_lookup(32'h0, 16'h0777, 5'd2, 1'b0, 2'd0, 2, "post_reset");

    // board_valid already high at reset release counts as a rising edge
    reset = 1'b0; uci_in = 16'h0777; pv_ply = 5'd2; board_valid = 1'b1;
    repeat (2) tick();
    reset = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!ev_a && n < 10);
    check("release_edge latency", n, 3);
    board_valid = 1'b0; clear_eval = 1'b1;
    tick();
    clear_eval = 1'b0;
    tick();

    // four-slot, latency-4 build: lowest of several matching slots wins
    use_b = 1'b1;
    wr(mk(16'h0D0D, 5'd1, 1'b1, 2'd2, 1'b0));
    wr(mk(16'h0D0D, 5'd1, 1'b1, 2'd3, 1'b0));
    run_lookup(32'h0, 16'h0D0D, 5'd1, 1'b1, 2'd2, 4, "b_two_match");
    wr(mk(16'h0D0D, 5'd1, 1'b0, 2'd2, 1'b0));
    run_lookup(32'h0, 16'h0D0D, 5'd1, 1'b1, 2'd3, 4, "b_slot3");
    run_lookup(32'h0, 16'h0E0E, 5'd1, 1'b0, 2'd0, 4, "b_nomatch");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
